// File: rtl/sync_delay_pkg.sv
// Shared types and helpers for the runtime-programmable sync delay line.
package sync_delay_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1,
    FILL = 2'd2
  } state_e;

  function automatic int unsigned ptr_w(input int unsigned max_delay);
    return $clog2(max_delay);
  endfunction

  function automatic int unsigned clamp_delay(input int unsigned req,
                                              input int unsigned max_delay);
    int unsigned res;
    if (req == 32'd0) begin
      res = 32'd1;
    end else if (req > max_delay) begin
      res = max_delay;
    end else begin
      res = req;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_delay_ctrl_if.sv
// Control-bus and config handshake bundle for sync_delay_ctrl.
// o_apply_cnt exists only when SYNC_DELAY_STATS_EN is defined.
interface sync_delay_ctrl_if
  import sync_delay_pkg::*;
#(
  parameter int BUS_BITS  = 3,
  parameter int MAX_DELAY = 32
);
  localparam int DW = ptr_w(MAX_DELAY) + 1;

  logic [BUS_BITS-1:0] i_bus;
  logic [DW-1:0]       cfg_delay;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [BUS_BITS-1:0] o_bus;
  logic                o_valid;
  logic                o_busy;

`ifdef SYNC_DELAY_STATS_EN
  logic [7:0]          o_apply_cnt;

  modport master (
    output i_bus, cfg_delay, cfg_valid,
    input  cfg_ready, o_bus, o_valid, o_busy, o_apply_cnt
  );
  modport slave (
    input  i_bus, cfg_delay, cfg_valid,
    output cfg_ready, o_bus, o_valid, o_busy, o_apply_cnt
  );
`else
  modport master (
    output i_bus, cfg_delay, cfg_valid,
    input  cfg_ready, o_bus, o_valid, o_busy
  );
  modport slave (
    input  i_bus, cfg_delay, cfg_valid,
    output cfg_ready, o_bus, o_valid, o_busy
  );
`endif

endinterface

// File: rtl/sync_delay_ram.sv
// Circular sample buffer: one synchronous write port, one asynchronous read port.
module sync_delay_ram #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage only; contents are never trusted until the controller has refilled them.
  always_ff @(posedge clk) begin
    mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_delay_ctrl.sv
// Runtime-programmable delay for the de/hsync/vsync bus; new delays take effect at vsync rise.
// Define SYNC_DELAY_STATS_EN to add the saturating o_apply_cnt switch counter.
module sync_delay_ctrl
  import sync_delay_pkg::*;
#(
  parameter int                  BUS_BITS      = 3,
  parameter int                  MAX_DELAY     = 32,
  parameter int                  DEFAULT_DELAY = 5,
  parameter int                  VSYNC_BIT     = 2,
  parameter logic [BUS_BITS-1:0] BLANK_VALUE   = {BUS_BITS{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  sync_delay_ctrl_if.slave bus
);

  localparam int             PTR_W = ptr_w(MAX_DELAY);
  localparam int             DW    = PTR_W + 1;
  localparam logic [DW-1:0]  DEF_D = DW'(DEFAULT_DELAY);
  localparam logic [DW-1:0]  ONE_D = {{(DW-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [DW-1:0]       d_q, d_d;
  logic [DW-1:0]       dnew_q, dnew_d;
  logic [PTR_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    wptr_q, wptr_d;
  logic                vs_q, vs_d;
  logic                primed_q, primed_d;
  logic [BUS_BITS-1:0] o_bus_q, o_bus_d;
  logic                o_valid_q, o_valid_d;
  logic                o_busy_q, o_busy_d;
  logic                cfg_ready_q, cfg_ready_d;

  logic [PTR_W-1:0]    raddr_s;
  logic [BUS_BITS-1:0] rdata_s;
  logic                cfg_acc_s;
  logic                vs_rise_s;
  logic [DW-1:0]       req_d_s;

  sync_delay_ram #(
    .WIDTH (BUS_BITS),
    .DEPTH (MAX_DELAY),
    .AW    (PTR_W)
  ) u_ram (
    .clk   (clk),
    .waddr (wptr_q),
    .wdata (bus.i_bus),
    .raddr (raddr_s),
    .rdata (rdata_s)
  );

  // Read slot is D behind the write slot; D==MAX_DELAY reads the slot about to be overwritten.
  always_comb begin
    raddr_s   = wptr_q - d_q[PTR_W-1:0];
    cfg_acc_s = bus.cfg_valid & cfg_ready_q;
    vs_rise_s = bus.i_bus[VSYNC_BIT] & ~vs_q;
    req_d_s   = DW'(clamp_delay(32'(bus.cfg_delay), 32'(MAX_DELAY)));
    wptr_d    = wptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    vs_d      = bus.i_bus[VSYNC_BIT];
  end

  // The first edge after reset writes the first real sample, so refill counting starts one edge later.
  always_comb begin
    state_d  = state_q;
    d_d      = d_q;
    dnew_d   = dnew_q;
    cnt_d    = cnt_q;
    primed_d = 1'b1;
    case (state_q)
      RUN: begin
        if (cfg_acc_s && (req_d_s != d_q)) begin
          dnew_d  = req_d_s;
          state_d = PEND;
        end else begin
          state_d = RUN;
        end
      end
      PEND: begin
        if (vs_rise_s) begin
          d_d     = dnew_q;
          cnt_d   = {PTR_W{1'b0}};
          state_d = FILL;
        end else begin
          state_d = PEND;
        end
      end
      FILL: begin
        if (!primed_q) begin
          cnt_d = cnt_q;
        end else if ({1'b0, cnt_q} == (d_q - ONE_D)) begin
          cnt_d   = {PTR_W{1'b0}};
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = {PTR_W{1'b0}};
      end
    endcase
  end

  // Outputs follow the next state so the first valid word is the sample taken at the switch edge.
  always_comb begin
    o_valid_d   = (state_d != FILL);
    o_busy_d    = (state_d != RUN);
    cfg_ready_d = (state_d == RUN);
    if (state_d == FILL) begin
      o_bus_d = BLANK_VALUE;
    end else begin
      o_bus_d = rdata_s;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      d_q         <= DEF_D;
      dnew_q      <= DEF_D;
      cnt_q       <= {PTR_W{1'b0}};
      wptr_q      <= {PTR_W{1'b0}};
      vs_q        <= 1'b0;
      primed_q    <= 1'b0;
      o_bus_q     <= BLANK_VALUE;
      o_valid_q   <= 1'b0;
      o_busy_q    <= 1'b1;
      cfg_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_q         <= d_d;
      dnew_q      <= dnew_d;
      cnt_q       <= cnt_d;
      wptr_q      <= wptr_d;
      vs_q        <= vs_d;
      primed_q    <= primed_d;
      o_bus_q     <= o_bus_d;
      o_valid_q   <= o_valid_d;
      o_busy_q    <= o_busy_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign bus.o_bus     = o_bus_q;
  assign bus.o_valid   = o_valid_q;
  assign bus.o_busy    = o_busy_q;
  assign bus.cfg_ready = cfg_ready_q;

`ifdef SYNC_DELAY_STATS_EN
  logic [7:0] apply_cnt_q, apply_cnt_d;

  // Saturating count of applied delay switches.
  always_comb begin
    if ((state_q == PEND) && (state_d == FILL) && (apply_cnt_q != 8'hFF)) begin
      apply_cnt_d = apply_cnt_q + 8'd1;
    end else begin
      apply_cnt_d = apply_cnt_q;
    end
  end

  // Switch counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      apply_cnt_q <= 8'd0;
    end else begin
      apply_cnt_q <= apply_cnt_d;
    end
  end

  assign bus.o_apply_cnt = apply_cnt_q;
`endif

endmodule

// File: tb/tb_sync_delay_ctrl.sv
// Self-checking bench for sync_delay_ctrl: a sample-history model plus directed literal checks.
module tb_sync_delay_ctrl;

  localparam int HN = 4096;

  logic clk;
  logic rst_n;

  sync_delay_ctrl_if #(.BUS_BITS(3), .MAX_DELAY(32)) bif ();

  sync_delay_ctrl #(
    .BUS_BITS      (3),
    .MAX_DELAY     (32),
    .DEFAULT_DELAY (5),
    .VSYNC_BIT     (2),
    .BLANK_VALUE   (3'd0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Model: a regime starts at a sample index; output is valid once D samples of it exist.
  logic [2:0] m_hist [HN];
  int   m_t, m_d, m_start, m_new, m_apply;
  logic m_pend, m_prev_vs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int r);
    if (r < 1) return 1;
    if (r > 32) return 32;
    return r;
  endfunction

  function automatic logic m_valid();
    return (m_t - m_start) >= m_d;
  endfunction

  task automatic model_reset();
    m_t = 0; m_d = 5; m_start = 1; m_new = 5; m_apply = 0;
    m_pend = 1'b0; m_prev_vs = 1'b0;
  endtask

  task automatic model_step();
    logic rise;
    logic rdy;
    int   c;
    rdy = !m_pend && m_valid();
    m_t++;
    m_hist[m_t % HN] = bif.i_bus;
    rise = bif.i_bus[2] && !m_prev_vs;
    m_prev_vs = bif.i_bus[2];
    if (m_pend && rise) begin
      m_d = m_new; m_start = m_t; m_pend = 1'b0;
      if (m_apply < 255) m_apply++;
    end else if (rdy && bif.cfg_valid) begin
      c = clamp(int'(bif.cfg_delay));
      if (c != m_d) begin
        m_pend = 1'b1; m_new = c;
      end
    end
  endtask

  task automatic compare_outputs();
    logic       ev;
    logic [2:0] eb;
    ev = m_valid();
    eb = ev ? m_hist[(m_t - m_d) % HN] : 3'd0;
    chk("cyc o_valid", 32'(bif.o_valid), 32'(ev));
    chk("cyc o_bus", 32'(bif.o_bus), 32'(eb));
    chk("cyc o_busy", 32'(bif.o_busy), 32'(m_pend || !ev));
    chk("cyc cfg_ready", 32'(bif.cfg_ready), 32'(!m_pend && ev));
`ifdef SYNC_DELAY_STATS_EN
    chk("cyc o_apply_cnt", 32'(bif.o_apply_cnt), 32'(m_apply));
`endif
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
      #1;
      compare_outputs();
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic [2:0] v, input logic cv, input logic [5:0] cd);
    bif.i_bus = v; bif.cfg_valid = cv; bif.cfg_delay = cd;
    @(posedge clk);
    @(negedge clk);
    bif.cfg_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bif.i_bus = 3'd0; bif.cfg_valid = 1'b0; bif.cfg_delay = 6'd0;
    repeat (3) @(negedge clk);
    chk("reset o_valid", 32'(bif.o_valid), 32'd0);
    chk("reset o_busy", 32'(bif.o_busy), 32'd1);
    chk("reset cfg_ready", 32'(bif.cfg_ready), 32'd0);
    chk("reset o_bus", 32'(bif.o_bus), 32'd0);
    rst_n = 1'b1;

    // T1: ramp after release, five invalid cycles then delay 5
    for (int k = 1; k <= 5; k++) begin
      step(3'(k % 4), 1'b0, 6'd0);
      chk("t1 invalid", 32'(bif.o_valid), 32'd0);
    end
    step(3'd2, 1'b0, 6'd0);
    chk("t1 first valid", 32'(bif.o_valid), 32'd1);
    chk("t1 first bus", 32'(bif.o_bus), 32'd1);
    chk("t1 busy low", 32'(bif.o_busy), 32'd0);
    step(3'd3, 1'b0, 6'd0);
    chk("t1 second bus", 32'(bif.o_bus), 32'd2);
    for (int k = 8; k <= 20; k++) step(3'(k % 4), 1'b0, 6'd0);

    // T2: request 12, long wait without vsync, then switch
    step(3'd0, 1'b1, 6'd12);
    chk("t2 ready low", 32'(bif.cfg_ready), 32'd0);
    chk("t2 busy", 32'(bif.o_busy), 32'd1);
    for (int j = 0; j < 100; j++) step(3'(j % 4), 1'b0, 6'd0);
    chk("t2 still old delay", 32'(bif.o_bus), 32'd2);
    chk("t2 still pending", 32'(bif.cfg_ready), 32'd0);
    chk("t2 pend valid", 32'(bif.o_valid), 32'd1);
    step(3'd4, 1'b0, 6'd0);
    chk("t2 blank at switch", 32'(bif.o_valid), 32'd0);
    chk("t2 model D", 32'(m_d), 32'd12);
    for (int j = 1; j <= 11; j++) begin
      step(3'(j % 4), 1'b0, 6'd0);
      chk("t2 blank", 32'(bif.o_valid), 32'd0);
    end
    step(3'd0, 1'b0, 6'd0);
    chk("t2 valid after 12", 32'(bif.o_valid), 32'd1);
    chk("t2 switch sample", 32'(bif.o_bus), 32'd4);
    chk("t2 busy clear", 32'(bif.o_busy), 32'd0);
    step(3'd0, 1'b0, 6'd0);
    chk("t2 next sample", 32'(bif.o_bus), 32'd1);

    // T3: clamp 0 -> 1, walking ones
    step(3'd0, 1'b1, 6'd0);
    chk("t3 accept", 32'(bif.cfg_ready), 32'd0);
    step(3'd4, 1'b0, 6'd0);
    chk("t3 model D min", 32'(m_d), 32'd1);
    step(3'd0, 1'b0, 6'd0);
    chk("t3 d1 valid", 32'(bif.o_valid), 32'd1);
    chk("t3 d1 sample", 32'(bif.o_bus), 32'd4);
    for (int j = 0; j < 12; j++) step(3'(1 << (j % 3)), 1'b0, 6'd0);
    chk("t3 d1 walk", 32'(bif.o_bus), 32'd2);

    // T3: clamp 40 -> 32
    step(3'd0, 1'b1, 6'd40);
    step(3'd4, 1'b0, 6'd0);
    chk("t3 model D max", 32'(m_d), 32'd32);
    for (int j = 1; j <= 31; j++) begin
      step(3'(1 << (j % 2)), 1'b0, 6'd0);
      chk("t3 d32 blank", 32'(bif.o_valid), 32'd0);
    end
    step(3'd0, 1'b0, 6'd0);
    chk("t3 d32 valid", 32'(bif.o_valid), 32'd1);
    chk("t3 d32 sample", 32'(bif.o_bus), 32'd4);
    step(3'd0, 1'b0, 6'd0);
    chk("t3 d32 next", 32'(bif.o_bus), 32'd2);
    for (int j = 0; j < 40; j++) step(3'(1 << (j % 3)), 1'b0, 6'd0);
    chk("t3 d32 walk", 32'(bif.o_bus), 32'd2);

    // T4: accept on the same edge as a vsync rise
    step(3'd0, 1'b0, 6'd0);
    step(3'd4, 1'b1, 6'd7);
    chk("t4 pending", 32'(bif.cfg_ready), 32'd0);
    chk("t4 no switch", 32'(bif.o_valid), 32'd1);
    for (int j = 0; j < 5; j++) step(3'd4, 1'b0, 6'd0);
    chk("t4 held valid", 32'(bif.o_valid), 32'd1);
    chk("t4 held busy", 32'(bif.o_busy), 32'd1);
    step(3'd0, 1'b0, 6'd0);
    step(3'd4, 1'b0, 6'd0);
    chk("t4 switch", 32'(bif.o_valid), 32'd0);
    chk("t4 model D", 32'(m_d), 32'd7);
    for (int j = 1; j <= 6; j++) step(3'd0, 1'b0, 6'd0);
    chk("t4 still blank", 32'(bif.o_valid), 32'd0);
    step(3'd0, 1'b0, 6'd0);
    chk("t4 valid", 32'(bif.o_valid), 32'd1);
    chk("t4 sample", 32'(bif.o_bus), 32'd4);

    // T5: reset during FILL
    step(3'd0, 1'b1, 6'd20);
    step(3'd4, 1'b0, 6'd0);
    repeat (3) step(3'd1, 1'b0, 6'd0);
    rst_n = 1'b0;
    #1;
    chk("t5 reset o_valid", 32'(bif.o_valid), 32'd0);
    chk("t5 reset o_busy", 32'(bif.o_busy), 32'd1);
    chk("t5 reset cfg_ready", 32'(bif.cfg_ready), 32'd0);
    chk("t5 reset o_bus", 32'(bif.o_bus), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step(3'(k), 1'b0, 6'd0);
      chk("t5 invalid", 32'(bif.o_valid), 32'd0);
    end
    step(3'd6, 1'b0, 6'd0);
    chk("t5 default delay valid", 32'(bif.o_valid), 32'd1);
    chk("t5 default delay bus", 32'(bif.o_bus), 32'd1);
    chk("t5 model D", 32'(m_d), 32'd5);

    // T6: many switches alternating between delay 1 and 2
    for (int i = 0; i < 300; i++) begin
      step(3'd0, 1'b1, (i % 2 == 0) ? 6'd1 : 6'd2);
      step(3'd4, 1'b0, 6'd0);
      repeat ((i % 2 == 0) ? 1 : 2) step(3'd0, 1'b0, 6'd0);
`ifdef SYNC_DELAY_STATS_EN
      if (i == 254) chk("t6 count 255", 32'(bif.o_apply_cnt), 32'd255);
`endif
    end
    chk("t6 run after switches", 32'(bif.cfg_ready), 32'd1);
`ifdef SYNC_DELAY_STATS_EN
    chk("t6 saturated", 32'(bif.o_apply_cnt), 32'd255);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
